mult_hilo_unit: RTL and testbench

Multi-cycle sequencer and HI/LO result register file for the 32x32 signed combinational multiplier in the KGP_RISC execute stage. It registers operands into the multiplier, then waits a fixed settle count so the multiplier path is a multicycle path. It captures the 64-bit product into HI/LO and exposes HI/LO to the move-from/move-to instructions. It sits between the ALU/decode control and the multiplier: it drives the multiplier's inputs and consumes its output.

---
 rtl/mult_hilo_unit.sv | 81 ++++++++
 tb/tb_mult_hilo_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: multicycle sequencer for the signed 32x32 multiplier plus the HI/LO result registers
module mult_hilo_unit #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [63:0] mul_p,
   input  logic        wr_hi,
   input  logic        wr_lo,
   input  logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, hi_q, hi_d, lo_q, lo_d;
   logic        done_q, done_d;
   // next state: accept start and HI/LO moves in IDLE, count down the settle time in WAIT and capture on the last count
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         hi_d = wr_hi ? wr_data : hi_q;
         lo_d = wr_lo ? wr_data : lo_q;
         if (start) begin
            mul_a_d = op_a;
            mul_b_d = op_b;
            cnt_d   = 4'(SETTLE_CYCLES);
            state_d = WAIT;
         end
      end else if (cnt_q == 4'd1) begin
         {hi_d, lo_d} = mul_p;
         done_d  = 1'b1;
         cnt_d   = 4'd0;
         state_d = IDLE;
      end else begin
         cnt_d = cnt_q - 4'd1;
      end
   end
   // state and datapath registers; reset abandons any multiply in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         mul_a_q <= 32'd0;
         mul_b_q <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end
   assign mul_a = mul_a_q;
   assign mul_b = mul_b_q;
   assign busy  = state_q == WAIT;
   assign stall = busy;
   assign done  = done_q;
   assign hi    = hi_q;
   assign lo    = lo_q;
endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb_mult_hilo_unit: directed and random checks of the multiply sequencer and HI/LO registers
module tb_mult_hilo_unit;
   localparam int S = 2;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
   logic [31:0] op_a = '0, op_b = '0, wr_data = '0;
   logic [31:0] mul_a, mul_b, hi, lo;
   logic [63:0] mul_p;
   logic        busy, done, stall;
   logic [31:0] hi_m = '0, lo_m = '0;
   int          errors = 0, checks = 0;

   mult_hilo_unit #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
      .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
      .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
   );

   // combinational multiplier seen by the unit
   assign mul_p = longint'($signed(mul_a)) * longint'($signed(mul_b));

   always #5 clk = ~clk;

   function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
      return longint'($signed(a)) * longint'($signed(b));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic busy_phase(input string tag);
      for (int i = 0; i < S; i++) begin
         chk1({tag, "_busy"}, busy, 1'b1);
         chk1({tag, "_stall"}, stall, 1'b1);
         chk1({tag, "_nodone"}, done, 1'b0);
         tick();
      end
   endtask

   task automatic done_phase(input string tag, input logic [63:0] p);
      hi_m = p[63:32];
      lo_m = p[31:0];
      chk1({tag, "_done"}, done, 1'b1);
      chk1({tag, "_idle"}, busy, 1'b0);
      chk1({tag, "_nostall"}, stall, 1'b0);
      chk32({tag, "_hi"}, hi, hi_m);
      chk32({tag, "_lo"}, lo, lo_m);
   endtask

   task automatic mul(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
      op_a = a;
      op_b = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk32({tag, "_mul_a"}, mul_a, a);
      chk32({tag, "_mul_b"}, mul_b, b);
      busy_phase(tag);
      done_phase(tag, p);
   endtask

   initial begin
      #2;
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk32("rst_hi", hi, 32'h0);
      chk32("rst_lo", lo, 32'h0);
      tick();
      rst = 1'b0;
      wr_hi = 1'b1;
      wr_lo = 1'b1;
      wr_data = 32'h0000_0055;
      tick();
      wr_hi = 1'b0;
      wr_lo = 1'b0;
      chk32("pre_rst_hi", hi, 32'h55);
      #2 rst = 1'b1;
      #1;
      chk32("async_rst_hi", hi, 32'h0);
      chk32("async_rst_lo", lo, 32'h0);
      chk1("async_rst_busy", busy, 1'b0);
      rst = 1'b0;
      tick();

      mul("basic", 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
      tick();
      chk1("done_one_cycle", done, 1'b0);
      chk32("hold_mul_a", mul_a, 32'd7);

      mul("min_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      mul("max_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
      mul("min_one", 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
      tick();

      op_a = 32'd5;
      op_b = 32'd6;
      start = 1'b1;
      tick();
      op_a = 32'd9;
      op_b = 32'd9;
      for (int i = 0; i < S; i++) begin
         chk32("ignored_mul_a", mul_a, 32'd5);
         chk1("b2b_busy", busy, 1'b1);
         tick();
      end
      done_phase("b2b_first", 64'd30);
      tick();
      start = 1'b0;
      chk1("no_bubble_busy", busy, 1'b1);
      chk32("b2b_mul_a", mul_a, 32'd9);
      busy_phase("b2b_second");
      done_phase("b2b_second", 64'd81);
      tick();

      wr_hi = 1'b1;
      wr_data = 32'hDEAD_BEEF;
      tick();
      wr_hi = 1'b0;
      hi_m = 32'hDEAD_BEEF;
      chk32("mthi_hi", hi, hi_m);
      chk32("mthi_lo", lo, lo_m);

      op_a = 32'd11;
      op_b = 32'hFFFF_FFFE;
      start = 1'b1;
      wr_hi = 1'b1;
      wr_data = 32'h0000_ABCD;
      tick();
      start = 1'b0;
      wr_hi = 1'b0;
      wr_lo = 1'b1;
      wr_data = 32'h1234_5678;
      chk32("start_mthi_hi", hi, 32'h0000_ABCD);
      busy_phase("wr_busy");
      chk32("mtlo_dropped", lo, 32'hFFFF_FFEA);
      wr_lo = 1'b0;
      done_phase("wr_busy", prod(32'd11, 32'hFFFF_FFFE));
      tick();

      op_a = 32'd100;
      op_b = 32'd200;
      start = 1'b1;
      tick();
      start = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk1("midrst_busy", busy, 1'b0);
      chk32("midrst_hi", hi, 32'h0);
      chk32("midrst_lo", lo, 32'h0);
      rst = 1'b0;
      for (int i = 0; i <= S; i++) begin
         tick();
         chk1("midrst_nodone", done, 1'b0);
      end
      mul("after_rst", 32'd3, 32'd4, 64'd12);
      tick();

      for (int n = 0; n < 20; n++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = $urandom;
         if (n % 3 == 0) begin
            wr_lo = 1'b1;
            wr_data = $urandom;
            tick();
            wr_lo = 1'b0;
            lo_m = wr_data;
            chk32("rand_mtlo", lo, lo_m);
            chk32("rand_mtlo_hi", hi, hi_m);
         end
         mul("rand", a, b, prod(a, b));
         if (n % 2 == 0) tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
